line_buffer_scanout: RTL and testbench

//  Read-side sequencer for a single-port synchronous line-buffer RAM (1-clk registered read,

---
 rtl/line_buffer_scanout.sv | 140 ++++++++++++++
 tb/tb_line_buffer_scanout.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_scanout.sv
// Read-side sequencer for a single-port line-buffer RAM with a registered read and
// read-before-write: walks LEN addresses from BASE, streams pixels out, optionally erases.
module line_buffer_scanout #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 10,
   parameter bit                    ERASE      = 1'b1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  pix_ce,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cen,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] pix_out,
   output logic                  pix_valid,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
   localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH:0]     remain_q, remain_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic                    ram_cen_q, ram_cen_d;
   logic                    ram_we_q, ram_we_d;
   logic                    rd_pend_q, rd_pend_d;
   logic [DATA_WIDTH-1:0]   pix_out_q, pix_out_d;
   logic                    pix_valid_q, pix_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   // Read pipeline: access cycle (ram_cen_q) -> RAM data cycle (rd_pend_q) -> pix_valid_q.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      ram_addr_d  = ram_addr_q;
      ram_cen_d   = 1'b0;
      ram_we_d    = 1'b0;
      rd_pend_d   = ram_cen_q;
      pix_valid_d = rd_pend_q;
      pix_out_d   = rd_pend_q ? ram_q : pix_out_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != LEN_ZERO) begin
                  addr_d   = base_addr;
                  remain_d = len;
                  busy_d   = 1'b1;
                  state_d  = S_SCAN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SCAN: begin
            if (pix_ce) begin
               ram_cen_d  = 1'b1;
               ram_we_d   = ERASE;
               ram_addr_d = addr_q;
               addr_d     = addr_q + 1'b1;
               remain_d   = remain_q - LEN_ONE;
               if (remain_q == LEN_ONE) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Only the final access is still in flight; finish once its pixel is out.
            if (pix_valid_q && !rd_pend_q && !ram_cen_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         ram_addr_q  <= '0;
         ram_cen_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         rd_pend_q   <= 1'b0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         ram_addr_q  <= ram_addr_d;
         ram_cen_q   <= ram_cen_d;
         ram_we_q    <= ram_we_d;
         rd_pend_q   <= rd_pend_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_data  = CLEAR_VAL;
   assign ram_cen   = ram_cen_q;
   assign ram_we    = ram_we_q;
   assign pix_out   = pix_out_q;
   assign pix_valid = pix_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_line_buffer_scanout.sv
// Bench for line_buffer_scanout: erase and read-only instances share stimulus; a timestamped
// event model predicts every output per cycle, plus literal checks of the directed scans.
module tb_line_buffer_scanout;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1024;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset, start, pix_ce;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic [AW-1:0] ram_addr[2];
  logic [DW-1:0] ram_data[2];
  logic ram_cen[2], ram_we[2];
  logic [DW-1:0] ram_q[2];
  logic [DW-1:0] pix_out[2];
  logic pix_valid[2], busy[2], done[2];
  logic [1:0] dbg_state[2];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_buffer_scanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERASE(1'b1), .CLEAR_VAL(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len), .pix_ce(pix_ce),
    .ram_addr(ram_addr[0]), .ram_data(ram_data[0]), .ram_cen(ram_cen[0]), .ram_we(ram_we[0]),
    .ram_q(ram_q[0]), .pix_out(pix_out[0]), .pix_valid(pix_valid[0]), .busy(busy[0]),
    .done(done[0]), .dbg_state(dbg_state[0]));

  line_buffer_scanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERASE(1'b0), .CLEAR_VAL(8'h00)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len), .pix_ce(pix_ce),
    .ram_addr(ram_addr[1]), .ram_data(ram_data[1]), .ram_cen(ram_cen[1]), .ram_we(ram_we[1]),
    .ram_q(ram_q[1]), .pix_out(pix_out[1]), .pix_valid(pix_valid[1]), .busy(busy[1]),
    .done(done[1]), .dbg_state(dbg_state[1]));

  function automatic bit [DW-1:0] init_val(input int a);
    return DW'((a + 1) & 255);
  endfunction

  // Single-port synchronous RAMs, read-before-write, preloaded with data = addr + 1.
  bit [DW-1:0] mem[2][DEPTH];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < DEPTH; a++) mem[i][a] <= init_val(a);
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ram_cen[i] === 1'b1) begin
          ram_q[i] <= mem[i][ram_addr[i]];
          if (ram_we[i] === 1'b1) mem[i][ram_addr[i]] <= ram_data[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_list(input string nm, input int got[$], input int exp_l[$]);
    chk({nm, "_count"}, got.size(), exp_l.size());
    for (int k = 0; k < exp_l.size() && k < got.size(); k++)
      chk($sformatf("%s[%0d]", nm, k), got[k], exp_l[k]);
  endtask

  // Model: expected events stored against the absolute cycle they must appear in.
  bit exp_cen[MAXC], exp_pv[MAXC], exp_busy[MAXC], exp_done[MAXC];
  bit [AW-1:0] exp_addr[MAXC];
  bit [DW-1:0] exp_pix[2][MAXC];
  bit [DW-1:0] sh[2][DEPTH];
  bit [DW-1:0] m_last[2];
  bit sh_init = 1'b0;
  bit armed = 1'b0;
  int m_phase = 0;
  int m_addr = 0, m_left = 0, m_done = 0;

  int log_cen_cyc[$], log_addr[$], log_pv_cyc[$], log_pix0[$], log_pix1[$], log_done_cyc[$];
  int busy_cnt = 0;
  int we1_cnt = 0;
  int last_start_cyc = 0;

  always @(negedge clk) begin
    if (!sh_init) begin
      for (int a = 0; a < DEPTH; a++) begin
        sh[0][a] = init_val(a);
        sh[1][a] = init_val(a);
      end
      sh_init = 1'b1;
    end
    if (cyc >= MAXC - 8) begin
      n_fail++;
      $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, MAXC - 8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_pv[cyc]) m_last[i] = exp_pix[i][cyc];
        chk($sformatf("ram_cen%0d", i), ram_cen[i], exp_cen[cyc]);
        chk($sformatf("ram_we%0d", i), ram_we[i], exp_cen[cyc] & (i == 0));
        if (exp_cen[cyc]) begin
          chk($sformatf("ram_addr%0d", i), ram_addr[i], exp_addr[cyc]);
          chk($sformatf("ram_data%0d", i), ram_data[i], 0);
        end
        chk($sformatf("pix_valid%0d", i), pix_valid[i], exp_pv[cyc]);
        chk($sformatf("pix_out%0d", i), pix_out[i], m_last[i]);
        chk($sformatf("busy%0d", i), busy[i], exp_busy[cyc]);
        chk($sformatf("done%0d", i), done[i], exp_done[cyc]);
      end
      if (ram_cen[0] === 1'b1) begin
        log_cen_cyc.push_back(cyc);
        log_addr.push_back(int'(ram_addr[0]));
      end
      if (pix_valid[0] === 1'b1) begin
        log_pv_cyc.push_back(cyc);
        log_pix0.push_back(int'(pix_out[0]));
      end
      if (pix_valid[1] === 1'b1) log_pix1.push_back(int'(pix_out[1]));
      if (done[0] === 1'b1) log_done_cyc.push_back(cyc);
      if (busy[0] === 1'b1) busy_cnt++;
      if (ram_we[1] === 1'b1) we1_cnt++;
    end
    if (reset === 1'b1) begin
      for (int k = cyc + 1; k < MAXC; k++) begin
        exp_cen[k] = 0; exp_pv[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
      end
      m_phase = 0;
      m_last[0] = 0;
      m_last[1] = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (m_phase == 2 && cyc >= m_done) m_phase = 0;
      if (m_phase == 0) begin
        if (start === 1'b1) begin
          if (int'(len) == 0) exp_done[cyc + 1] = 1;
          else begin
            m_phase = 1; m_addr = int'(base_addr); m_left = int'(len);
          end
        end
      end else if (m_phase == 1) begin
        if (pix_ce === 1'b1) begin
          exp_cen[cyc + 1] = 1;
          exp_addr[cyc + 1] = AW'(m_addr);
          exp_pv[cyc + 3] = 1;
          exp_pix[0][cyc + 3] = sh[0][m_addr];
          exp_pix[1][cyc + 3] = sh[1][m_addr];
          sh[0][m_addr] = 8'h00;
          m_addr = (m_addr + 1) % DEPTH;
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_done = cyc + 4; exp_done[cyc + 4] = 1;
          end
        end
      end
      exp_busy[cyc + 1] = (m_phase == 1) || (m_phase == 2 && cyc + 1 < m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_cen_cyc.delete(); log_addr.delete(); log_pv_cyc.delete();
    log_pix0.delete(); log_pix1.delete(); log_done_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic pulse_start(input int b, input int l);
    base_addr = AW'(b);
    len = LW'(l);
    start = 1'b1;
    last_start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target, input int limit);
    int n = 0;
    while (log_done_cyc.size() < target && n < limit) begin
      tick();
      n++;
    end
    chk(nm, log_done_cyc.size() >= target, 1);
  endtask

  initial begin
    int ex[$];
    int diffs;
    int s;
    reset = 1'b1; start = 1'b0; pix_ce = 1'b0; base_addr = '0; len = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Erase scan across the top-of-buffer wrap.
    pix_ce = 1'b1;
    clear_logs();
    pulse_start('h3FE, 4);
    wait_done("t2_done_seen", 1, 40);
    repeat (3) tick();
    ex = '{'h3FE, 'h3FF, 'h000, 'h001};
    chk_list("t2_addr", log_addr, ex);
    ex = '{'hFF, 'h00, 'h01, 'h02};
    chk_list("t2_pix", log_pix0, ex);
    chk("t2_done_count", log_done_cyc.size(), 1);
    chk("t2_ram_3fe", mem[0][10'h3FE], 8'h00);
    chk("t2_ram_001", mem[0][10'h001], 8'h00);
    chk("t2_ram_002", mem[0][10'h002], 8'h03);

    // Re-read shows erased words; read-only instance still returns the originals.
    clear_logs();
    pulse_start('h3FE, 5);
    wait_done("t2r_done_seen", 1, 40);
    ex = '{'h00, 'h00, 'h00, 'h00, 'h03};
    chk_list("t2r_pix0", log_pix0, ex);
    ex = '{'hFF, 'h00, 'h01, 'h02, 'h03};
    chk_list("t2r_pix1", log_pix1, ex);

    // Sparse pixel enable.
    tick();
    clear_logs();
    pix_ce = 1'b0;
    pulse_start('h100, 5);
    for (int k = 1; k < 60 && log_done_cyc.size() == 0; k++) begin
      pix_ce = (k % 3 == 1);
      tick();
    end
    pix_ce = 1'b0;
    chk("t3_cen_count", log_cen_cyc.size(), 5);
    chk("t3_pv_count", log_pv_cyc.size(), 5);
    chk("t3_done_count", log_done_cyc.size(), 1);
    if (log_cen_cyc.size() == 5 && log_pv_cyc.size() == 5 && log_done_cyc.size() == 1) begin
      for (int k = 1; k < 5; k++) chk("t3_cen_spacing", log_cen_cyc[k] - log_cen_cyc[k-1], 3);
      for (int k = 0; k < 5; k++) chk("t3_pv_lag", log_pv_cyc[k] - log_cen_cyc[k], 2);
      chk("t3_done_lag", log_done_cyc[0] - log_pv_cyc[4], 1);
    end

    // Zero-length scan.
    tick();
    clear_logs();
    pix_ce = 1'b1;
    pulse_start('h123, 0);
    s = last_start_cyc;
    repeat (4) tick();
    chk("t4_done_count", log_done_cyc.size(), 1);
    if (log_done_cyc.size() == 1) chk("t4_done_cycle", log_done_cyc[0], s + 1);
    chk("t4_cen_count", log_cen_cyc.size(), 0);
    chk("t4_busy_cycles", busy_cnt, 0);

    // Start re-pulsed mid-scan must be ignored.
    clear_logs();
    pulse_start('h010, 6);
    pulse_start('h300, 3);
    wait_done("t5_done_seen", 1, 40);
    repeat (4) tick();
    ex = '{'h010, 'h011, 'h012, 'h013, 'h014, 'h015};
    chk_list("t5_addr", log_addr, ex);
    ex = '{'h11, 'h12, 'h13, 'h14, 'h15, 'h16};
    chk_list("t5_pix0", log_pix0, ex);
    chk_list("t5_pix1", log_pix1, ex);
    chk("t5_done_count", log_done_cyc.size(), 1);

    // Start coincident with done is accepted.
    clear_logs();
    pulse_start('h020, 2);
    s = last_start_cyc;
    repeat (5) tick();
    pulse_start('h030, 2);
    wait_done("t7_done_seen", 2, 40);
    ex = '{'h020, 'h021, 'h030, 'h031};
    chk_list("t7_addr", log_addr, ex);
    chk("t7_first_done", log_done_cyc[0], s + 6);

    // Reset held two clocks in the middle of a scan.
    tick();
    clear_logs();
    pulse_start('h040, 8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_ram_cen", ram_cen[0], 0);
    chk("t1_ram_we", ram_we[0], 0);
    chk("t1_ram_addr", ram_addr[0], 0);
    chk("t1_pix_valid", pix_valid[0], 0);
    chk("t1_pix_out", pix_out[0], 0);
    chk("t1_busy", busy[0], 0);
    chk("t1_done", done[0], 0);
    chk("t1_state", dbg_state[0], 0);
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (20) tick();
    chk("t1_cen_after_reset", log_cen_cyc.size(), 0);
    chk("t1_pv_after_reset", log_pv_cyc.size(), 0);
    chk("t1_done_after_reset", log_done_cyc.size(), 0);

    // Full-depth scan wrapping past the top.
    clear_logs();
    pix_ce = 1'b1;
    pulse_start('h200, 1024);
    wait_done("t6_done_seen", 1, 1100);
    tick();
    chk("t6_busy_cycles", busy_cnt, 1027);
    chk("t6_cen_count", log_addr.size(), 1024);
    chk("t6_pv_count", log_pv_cyc.size(), 1024);
    if (log_addr.size() == 1024) begin
      chk("t6_addr_first", log_addr[0], 'h200);
      chk("t6_addr_top", log_addr[511], 'h3FF);
      chk("t6_addr_wrap", log_addr[512], 'h000);
      chk("t6_addr_last", log_addr[1023], 'h1FF);
    end

    // Read-only instance never wrote.
    diffs = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[1][a] != init_val(a)) diffs++;
    chk("ro_ram_unchanged", diffs, 0);
    chk("ro_we_pulses", we1_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
